// File: rtl/sddr_line_buffer.sv
// sddr_line_buffer: one-line write-back buffer between a 32-bit CPU request
// port and a burst-wide DDR data port. Hits are served from the held line.
// A miss writes back the dirty line, then fills the new one.
// Optional flush support is compiled in by defining SDDR_LINE_BUFFER_FLUSH_EN.
module sddr_line_buffer #(
  parameter int ADDRESS_BITS = 27,
  parameter int LINE_BITS    = 128
) (
  input  logic                    cpu_clock_i,
  input  logic                    reset_i,
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
  input  logic                    flush_i,
  output logic                    flush_done_o,
`endif
  input  logic                    cpu_req_valid_i,
  input  logic [ADDRESS_BITS-1:0] cpu_req_addr_i,
  input  logic                    cpu_req_write_i,
  input  logic [31:0]             cpu_req_wdata_i,
  input  logic [3:0]              cpu_req_be_i,
  output logic                    cpu_req_ready_o,
  output logic                    cpu_rsp_valid_o,
  output logic [31:0]             cpu_rsp_data_o,
  output logic                    data_cmd_valid_o,
  output logic [ADDRESS_BITS-1:0] data_cmd_address_o,
  output logic                    data_cmd_write_o,
  output logic [LINE_BITS-1:0]    data_cmd_data_o,
  input  logic                    data_cmd_ack_i,
  input  logic                    data_rsp_ready_i,
  input  logic [LINE_BITS-1:0]    data_rsp_data_i
);

  localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
  localparam int TAG_BITS  = ADDRESS_BITS - OFF_BITS;
  localparam int WIDX_BITS = OFF_BITS - 2;

  typedef enum logic [1:0] {IDLE, WB_ISSUE, FILL_ISSUE, FILL_WAIT} state_t;

  state_t               state_q, state_d;
  logic [TAG_BITS-1:0]  tag_q;
  logic [TAG_BITS-1:0]  miss_tag_q;
  logic [LINE_BITS-1:0] line_q;
  logic                 valid_q;
  logic                 dirty_q;
  logic                 rsp_valid_q;
  logic [31:0]          rsp_data_q;
  logic                 rsp_hist_q;
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
  logic                 flush_q;
  logic                 flush_done_q;
`endif

  logic [TAG_BITS-1:0]  req_tag;
  logic [WIDX_BITS-1:0] req_widx;
  logic                 hit;
  logic                 miss_start;
  logic                 cmd_acc;
  logic                 rsp_rise;
  logic                 unused_addr_lsb;

  // Extract the 32-bit word at index idx from a line.
  function automatic logic [31:0] read_word(input logic [LINE_BITS-1:0] line,
                                            input logic [WIDX_BITS-1:0] idx);
    return line[32*int'(idx) +: 32];
  endfunction

  // Overwrite only the byte lanes enabled in be within word idx.
  function automatic logic [LINE_BITS-1:0] merge_store(input logic [LINE_BITS-1:0] line,
                                                       input logic [WIDX_BITS-1:0] idx,
                                                       input logic [31:0]          wdata,
                                                       input logic [3:0]           be);
    logic [LINE_BITS-1:0] merged;
    merged = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[32*int'(idx) + 8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

  assign req_tag  = cpu_req_addr_i[ADDRESS_BITS-1:OFF_BITS];
  assign req_widx = cpu_req_addr_i[OFF_BITS-1:2];
  assign hit      = valid_q && (tag_q == req_tag);
  assign cmd_acc  = data_cmd_valid_o && data_cmd_ack_i;
  // Only a fresh low-to-high transition of the response level counts; a level
  // left high by an earlier read is stale.
  assign rsp_rise = data_rsp_ready_i && !rsp_hist_q;
  // Byte-offset bits inside a word are don't-care for word accesses.
  assign unused_addr_lsb = ^cpu_req_addr_i[1:0];

`ifdef SDDR_LINE_BUFFER_FLUSH_EN
  assign miss_start   = (state_q == IDLE) && cpu_req_valid_i && !hit && !flush_i;
  assign flush_done_o = flush_done_q;
`else
  assign miss_start   = (state_q == IDLE) && cpu_req_valid_i && !hit;
`endif

  assign cpu_rsp_valid_o = rsp_valid_q;
  assign cpu_rsp_data_o  = rsp_data_q;

  // State register.
  always_ff @(posedge cpu_clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: miss handling, write-back, fill issue and fill wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
        if (flush_i && valid_q && dirty_q) state_d = WB_ISSUE;
`endif
        if (miss_start) state_d = (valid_q && dirty_q) ? WB_ISSUE : FILL_ISSUE;
      end
      WB_ISSUE: begin
        if (cmd_acc) begin
          state_d = FILL_ISSUE;
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
          if (flush_q) state_d = IDLE;
`endif
        end
      end
      FILL_ISSUE: if (cmd_acc) state_d = FILL_WAIT;
      FILL_WAIT:  if (rsp_rise) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; all handshakes are forced low during reset.
  always_comb begin
    cpu_req_ready_o    = 1'b0;
    data_cmd_valid_o   = 1'b0;
    data_cmd_write_o   = 1'b0;
    data_cmd_address_o = '0;
    data_cmd_data_o    = line_q;
    if (!reset_i) begin
      unique case (state_q)
        IDLE: begin
          cpu_req_ready_o = cpu_req_valid_i && hit;
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
          if (flush_i) cpu_req_ready_o = 1'b0;
`endif
        end
        WB_ISSUE: begin
          data_cmd_valid_o   = 1'b1;
          data_cmd_write_o   = 1'b1;
          data_cmd_address_o = {tag_q, {OFF_BITS{1'b0}}};
        end
        FILL_ISSUE: begin
          data_cmd_valid_o   = 1'b1;
          data_cmd_address_o = {miss_tag_q, {OFF_BITS{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  // Line storage, tag/valid/dirty bookkeeping and the CPU response register.
  always_ff @(posedge cpu_clock_i) begin
    if (reset_i) begin
      valid_q      <= 1'b0;
      dirty_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_hist_q   <= 1'b1;
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
      flush_q      <= 1'b0;
      flush_done_q <= 1'b0;
`endif
    end else begin
      rsp_hist_q  <= data_rsp_ready_i;
      rsp_valid_q <= cpu_req_ready_o;
      if (cpu_req_ready_o) begin
        if (cpu_req_write_i) begin
          line_q     <= merge_store(line_q, req_widx, cpu_req_wdata_i, cpu_req_be_i);
          dirty_q    <= 1'b1;
          rsp_data_q <= '0;
        end else begin
          rsp_data_q <= read_word(line_q, req_widx);
        end
      end
      // The fill address is latched so the command payload cannot move.
      if (miss_start) miss_tag_q <= req_tag;
      if ((state_q == WB_ISSUE) && cmd_acc) dirty_q <= 1'b0;
      if ((state_q == FILL_WAIT) && rsp_rise) begin
        line_q  <= data_rsp_data_i;
        tag_q   <= miss_tag_q;
        valid_q <= 1'b1;
        dirty_q <= 1'b0;
      end
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
      flush_done_q <= 1'b0;
      if ((state_q == IDLE) && flush_i) begin
        if (valid_q && dirty_q) begin
          flush_q <= 1'b1;
        end else begin
          valid_q      <= 1'b0;
          flush_done_q <= 1'b1;
        end
      end
      if ((state_q == WB_ISSUE) && cmd_acc && flush_q) begin
        flush_q      <= 1'b0;
        valid_q      <= 1'b0;
        flush_done_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sddr_line_buffer.sv
// Directed, table-driven bench for sddr_line_buffer with a small DDR responder.
module tb_sddr_line_buffer;

  localparam int AW = 27;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          cpu_req_valid_i = 1'b0;
  logic [AW-1:0] cpu_req_addr_i = '0;
  logic          cpu_req_write_i = 1'b0;
  logic [31:0]   cpu_req_wdata_i = '0;
  logic [3:0]    cpu_req_be_i = '0;
  logic          cpu_req_ready_o;
  logic          cpu_rsp_valid_o;
  logic [31:0]   cpu_rsp_data_o;
  logic          data_cmd_valid_o;
  logic [AW-1:0] data_cmd_address_o;
  logic          data_cmd_write_o;
  logic [LW-1:0] data_cmd_data_o;
  logic          data_cmd_ack_i = 1'b0;
  logic          data_rsp_ready_i = 1'b1;
  logic [LW-1:0] data_rsp_data_i = {4{32'hBAD0BAD0}};
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
  logic          flush_i = 1'b0;
  logic          flush_done_o;
`endif

  sddr_line_buffer #(.ADDRESS_BITS(AW), .LINE_BITS(LW)) dut (
    .cpu_clock_i       (clk),
    .reset_i           (reset_i),
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
    .flush_i           (flush_i),
    .flush_done_o      (flush_done_o),
`endif
    .cpu_req_valid_i   (cpu_req_valid_i),
    .cpu_req_addr_i    (cpu_req_addr_i),
    .cpu_req_write_i   (cpu_req_write_i),
    .cpu_req_wdata_i   (cpu_req_wdata_i),
    .cpu_req_be_i      (cpu_req_be_i),
    .cpu_req_ready_o   (cpu_req_ready_o),
    .cpu_rsp_valid_o   (cpu_rsp_valid_o),
    .cpu_rsp_data_o    (cpu_rsp_data_o),
    .data_cmd_valid_o  (data_cmd_valid_o),
    .data_cmd_address_o(data_cmd_address_o),
    .data_cmd_write_o  (data_cmd_write_o),
    .data_cmd_data_o   (data_cmd_data_o),
    .data_cmd_ack_i    (data_cmd_ack_i),
    .data_rsp_ready_i  (data_rsp_ready_i),
    .data_rsp_data_i   (data_rsp_data_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // DDR model: line memory, command log and read-response sequencer.
  logic [LW-1:0] mem [logic [AW-1:0]];
  bit            q_wr[$];
  logic [AW-1:0] q_addr[$];
  logic [LW-1:0] q_data[$];
  int            stale_cycles = 0;
  int            rd_cnt = 0;
  logic [AW-1:0] rd_line = '0;

  always @(negedge clk) begin
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 1) begin
        data_rsp_ready_i = 1'b0;
      end else if (rd_cnt == 0) begin
        data_rsp_data_i  = mem.exists(rd_line) ? mem[rd_line] : {4{32'hEEEE0000}};
        data_rsp_ready_i = 1'b1;
      end else begin
        data_rsp_data_i = {4{32'hBAD0BAD0}};
      end
    end
    if (data_cmd_ack_i) begin
      data_cmd_ack_i = 1'b0;
    end else if (data_cmd_valid_o) begin
      data_cmd_ack_i = 1'b1;
      q_wr.push_back(data_cmd_write_o);
      q_addr.push_back(data_cmd_address_o);
      q_data.push_back(data_cmd_data_o);
      if (data_cmd_write_o) begin
        mem[data_cmd_address_o] = data_cmd_data_o;
      end else begin
        rd_line = data_cmd_address_o;
        rd_cnt  = stale_cycles + 2;
      end
    end
  end

  typedef struct {
    string         name;
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic [31:0]   exp;
    int            n_rd;
    int            n_wr;
    logic [AW-1:0] wb_addr;
    logic [LW-1:0] wb_data;
    logic [AW-1:0] rd_addr;
    int            stale;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one CPU request, serve DDR traffic, and compare response and commands.
  task automatic run_vec(input vec_t v);
    int base;
    int nr;
    int nw;
    int idx;
    bit acc;
    stale_cycles = v.stale;
    base = q_wr.size();
    @(negedge clk);
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = v.addr;
    cpu_req_write_i = v.wr;
    cpu_req_wdata_i = v.wdata;
    cpu_req_be_i    = v.be;
    acc = 1'b0;
    for (int c = 0; c < 400 && !acc; c++) begin
      #1;
      acc = cpu_req_ready_o;
      @(negedge clk);
    end
    cpu_req_valid_i = 1'b0;
    check({v.name, " accepted"}, LW'(acc), LW'(1));
    #1;
    check({v.name, " rsp_valid"}, LW'(cpu_rsp_valid_o), LW'(1));
    check({v.name, " rsp_data"}, LW'(cpu_rsp_data_o), LW'(v.exp));
    nr = 0;
    nw = 0;
    for (int i = base; i < q_wr.size(); i++) begin
      if (q_wr[i]) nw++;
      else         nr++;
    end
    check({v.name, " n_reads"}, LW'(nr), LW'(v.n_rd));
    check({v.name, " n_writes"}, LW'(nw), LW'(v.n_wr));
    if (v.n_wr > 0 && q_wr.size() > base) begin
      check({v.name, " wb_first"}, LW'(q_wr[base]), LW'(1));
      check({v.name, " wb_addr"}, LW'(q_addr[base]), LW'(v.wb_addr));
      check({v.name, " wb_data"}, q_data[base], v.wb_data);
    end
    idx = base + v.n_wr;
    if (v.n_rd > 0 && q_wr.size() > idx) begin
      check({v.name, " rd_is_read"}, LW'(q_wr[idx]), LW'(0));
      check({v.name, " rd_addr"}, LW'(q_addr[idx]), LW'(v.rd_addr));
    end
    @(negedge clk);
    #1;
    check({v.name, " rsp_pulse"}, LW'(cpu_rsp_valid_o), LW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   spur;
    bit   seen;
    vec_t v;
`ifdef SDDR_LINE_BUFFER_FLUSH_EN
    int   dones;
`endif

    mem[27'h0000010] = {32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF};
    mem[27'h0000100] = {32'h40004000, 32'h30003000, 32'h20002000, 32'h10001000};
    mem[27'h0000200] = {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000};
    mem[27'h0000300] = {32'h30030003, 32'h30030002, 32'h30030001, 32'h30030000};
    mem[27'h0000400] = {32'h40040003, 32'h40040002, 32'h40040001, 32'h40040000};
    mem[27'h7FFFFF0] = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};

    //          name            wr  addr          wdata         be       exp           rd wr wb_addr      wb_data                                                      rd_addr       stale
    vecs[0]  = '{"cold_ld",     0, 27'h0000010, 32'h0,        4'b0000, 32'hDEADBEEF, 1, 0, 27'h0,       '0,                                                          27'h0000010, 0};
    vecs[1]  = '{"hit_ld_w1",   0, 27'h0000014, 32'h0,        4'b0000, 32'hCAFEF00D, 0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[2]  = '{"st_lo",       1, 27'h0000014, 32'h12345678, 4'b0011, 32'h0,        0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[3]  = '{"ld_after_st", 0, 27'h0000014, 32'h0,        4'b0000, 32'hCAFE5678, 0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[4]  = '{"st_hi",       1, 27'h0000018, 32'hAABBCCDD, 4'b1100, 32'h0,        0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[5]  = '{"ld_w2",       0, 27'h0000018, 32'h0,        4'b0000, 32'hAABB4567, 0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[6]  = '{"st_full",     1, 27'h000001C, 32'h0BADF00D, 4'b1111, 32'h0,        0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[7]  = '{"dirty_miss",  0, 27'h0000100, 32'h0,        4'b0000, 32'h10001000, 1, 1, 27'h0000010, {32'h0BADF00D, 32'hAABB4567, 32'hCAFE5678, 32'hDEADBEEF}, 27'h0000100, 0};
    vecs[8]  = '{"hit_w3",      0, 27'h000010C, 32'h0,        4'b0000, 32'h40004000, 0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[9]  = '{"clean_miss",  0, 27'h0000208, 32'h0,        4'b0000, 32'h5A5A0002, 1, 0, 27'h0,       '0,                                                          27'h0000200, 0};
    vecs[10] = '{"ign_lsb",     0, 27'h000020B, 32'h0,        4'b0000, 32'h5A5A0002, 0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[11] = '{"reload_wb",   0, 27'h0000014, 32'h0,        4'b0000, 32'hCAFE5678, 1, 0, 27'h0,       '0,                                                          27'h0000010, 0};
    vecs[12] = '{"st_byte0",    1, 27'h0000010, 32'h00C0FFEE, 4'b0001, 32'h0,        0, 0, 27'h0,       '0,                                                          27'h0,       0};
    vecs[13] = '{"top_tag",     0, 27'h7FFFFF4, 32'h0,        4'b0000, 32'hE1E1E1E1, 1, 1, 27'h0000010, {32'h0BADF00D, 32'hAABB4567, 32'hCAFE5678, 32'hDEADBEEE}, 27'h7FFFFF0, 0};
    vecs[14] = '{"stale_rsp",   0, 27'h0000300, 32'h0,        4'b0000, 32'h30030000, 1, 0, 27'h0,       '0,                                                          27'h0000300, 4};
    vecs[15] = '{"hit_after",   0, 27'h000030C, 32'h0,        4'b0000, 32'h30030003, 0, 0, 27'h0,       '0,                                                          27'h0,       0};

    // Reset state with a request pending on the inputs.
    reset_i         = 1'b1;
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = 27'h0000010;
    repeat (3) @(negedge clk);
    #1;
    check("rst ready", LW'(cpu_req_ready_o), LW'(0));
    check("rst rsp_valid", LW'(cpu_rsp_valid_o), LW'(0));
    check("rst rsp_data", LW'(cpu_rsp_data_o), LW'(0));
    check("rst cmd_valid", LW'(data_cmd_valid_o), LW'(0));
    check("rst cmd_write", LW'(data_cmd_write_o), LW'(0));
    @(negedge clk);
    cpu_req_valid_i = 1'b0;
    reset_i         = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i]);
    end

    // Reset while waiting for a fill; the late response must be ignored.
    stale_cycles = 6;
    base = q_wr.size();
    @(negedge clk);
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = 27'h0000400;
    cpu_req_write_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = (q_wr.size() > base);
    end
    check("midrst read_issued", LW'(seen), LW'(1));
    repeat (2) @(negedge clk);
    reset_i         = 1'b1;
    cpu_req_valid_i = 1'b0;
    #1;
    check("midrst cmd_valid", LW'(data_cmd_valid_o), LW'(0));
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    spur = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (cpu_rsp_valid_o || data_cmd_valid_o) spur++;
    end
    check("midrst quiet", LW'(spur), LW'(0));
    check("midrst no_new_cmd", LW'(q_wr.size() - base), LW'(1));
    v = '{"fresh_read", 0, 27'h0000404, 32'h0, 4'b0000, 32'h40040001, 1, 0, 27'h0, '0, 27'h0000400, 0};
    run_vec(v);

`ifdef SDDR_LINE_BUFFER_FLUSH_EN
    // Flush of a dirty line: one write-back, one done pulse, then a miss.
    v = '{"pre_flush_st", 1, 27'h0000400, 32'h11111111, 4'b1111, 32'h0, 0, 0, 27'h0, '0, 27'h0, 0};
    run_vec(v);
    base  = q_wr.size();
    dones = 0;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (flush_done_o) dones++;
      @(negedge clk);
    end
    check("flush n_cmds", LW'(q_wr.size() - base), LW'(1));
    if (q_wr.size() > base) begin
      check("flush is_write", LW'(q_wr[base]), LW'(1));
      check("flush addr", LW'(q_addr[base]), LW'(27'h0000400));
      check("flush data", q_data[base], {32'h40040003, 32'h40040002, 32'h40040001, 32'h11111111});
    end
    check("flush done_pulses", LW'(dones), LW'(1));
    v = '{"post_flush_ld", 0, 27'h0000404, 32'h0, 4'b0000, 32'h40040001, 1, 0, 27'h0, '0, 27'h0000400, 0};
    run_vec(v);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
